uart_tx: RTL and testbench

Serial UART transmitter; the transmit-side counterpart of the receive path. It accepts parallel bytes over a valid/ready handshake and emits standard asynchronous frames on a single line: start bit low, data LSB first, optional parity, stop bits high. Each bit lasts a fixed number of `clk` cycles. The block sits between the host-side data source and the `txd` pad, and its frames are decodable by the team's receiver at the same bit timing.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_tx.sv | 171 +++++++++++++++++
 tb/tb_uart_tx.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART package: transmitter FSM states, default bit timing and a parity helper.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 16;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } uart_tx_state_t;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic uart_parity(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side byte handshake into the UART transmitter (valid/ready, data LSB sent first).
interface uart_tx_if #(
    parameter int DATA_BITS = uart_pkg::UART_DATA_BITS
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-time counter: counts enabled cycles and flags the last cycle of each bit period.
// bit_pre_tick marks the cycle just before bit_tick, so callers can prepare registered outputs.
module uart_baud_tick import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_tick,
    output logic bit_pre_tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] count_r;

    // Free-running bit-period counter, restarted at the beginning of every frame.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_r <= '0;
        end else if (enable) begin
            count_r <= (count_r == LAST) ? '0 : count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign bit_tick     = enable && (count_r == LAST);
    assign bit_pre_tick = enable && (count_r == PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to compile in the parity bit (sense chosen by PARITY_ODD).
module uart_tx import uart_pkg::*; #(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      gl_reset,
    uart_tx_if.slave  tx_if,
    output logic      txd,
    output logic      busy
);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
        (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
        $error("uart_tx: illegal parameter value");
    end

    uart_tx_state_t       state_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [IW-1:0]        bit_idx_r;
    logic                 txd_r;
    logic                 busy_r;
    logic                 ready_r;
`ifdef UART_TX_PARITY_EN
    logic                 par_r;
`endif

    logic rst_s;
    logic accept_s;
    logic bit_tick_s;
    logic bit_pre_tick_s;

    assign rst_s    = reset | gl_reset;
    assign accept_s = tx_if.tx_valid & ready_r;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk          (clk),
        .reset        (rst_s),
        .clear        (accept_s),
        .enable       (busy_r),
        .bit_tick     (bit_tick_s),
        .bit_pre_tick (bit_pre_tick_s)
    );

    // Frame sequencer; txd, busy and tx_ready are all registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst_s) begin
            state_r   <= TX_IDLE;
            shift_r   <= '0;
            bit_idx_r <= '0;
            txd_r     <= 1'b1;
            busy_r    <= 1'b0;
            ready_r   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                TX_IDLE: begin
                    if (accept_s) begin
                        state_r   <= TX_START;
                        shift_r   <= tx_if.tx_data;
                        bit_idx_r <= '0;
                        txd_r     <= 1'b0;
                        busy_r    <= 1'b1;
                        ready_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
                        par_r     <= uart_parity(8'(tx_if.tx_data), 1'(PARITY_ODD));
`endif
                    end else begin
                        txd_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                TX_START: begin
                    ready_r <= 1'b0;
                    if (bit_tick_s) begin
                        state_r   <= TX_DATA;
                        txd_r     <= shift_r[0];
                        shift_r   <= shift_r >> 1;
                        bit_idx_r <= '0;
                    end else begin
                        txd_r <= 1'b0;
                    end
                end
                TX_DATA: begin
                    ready_r <= 1'b0;
                    if (bit_tick_s) begin
                        if (bit_idx_r == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                            state_r <= TX_PARITY;
                            txd_r   <= par_r;
`else
                            state_r <= TX_STOP;
                            txd_r   <= 1'b1;
`endif
                            bit_idx_r <= '0;
                        end else begin
                            txd_r     <= shift_r[0];
                            shift_r   <= shift_r >> 1;
                            bit_idx_r <= bit_idx_r + IW'(1);
                        end
                    end else begin
                        txd_r <= txd_r;
                    end
                end
`ifdef UART_TX_PARITY_EN
                TX_PARITY: begin
                    ready_r <= 1'b0;
                    if (bit_tick_s) begin
                        state_r   <= TX_STOP;
                        txd_r     <= 1'b1;
                        bit_idx_r <= '0;
                    end else begin
                        txd_r <= par_r;
                    end
                end
`endif
                TX_STOP: begin
                    txd_r <= 1'b1;
                    if (bit_tick_s && (bit_idx_r == LAST_STOP)) begin
                        // Final stop cycle: a byte accepted here starts the next frame at once.
                        if (accept_s) begin
                            state_r   <= TX_START;
                            shift_r   <= tx_if.tx_data;
                            bit_idx_r <= '0;
                            txd_r     <= 1'b0;
                            busy_r    <= 1'b1;
                            ready_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            par_r     <= uart_parity(8'(tx_if.tx_data), 1'(PARITY_ODD));
`endif
                        end else begin
                            state_r <= TX_IDLE;
                            busy_r  <= 1'b0;
                            ready_r <= 1'b1;
                        end
                    end else if (bit_tick_s) begin
                        bit_idx_r <= bit_idx_r + IW'(1);
                        ready_r   <= 1'b0;
                    end else begin
                        ready_r <= bit_pre_tick_s && (bit_idx_r == LAST_STOP);
                    end
                end
                default: begin
                    state_r   <= TX_IDLE;
                    bit_idx_r <= '0;
                    txd_r     <= 1'b1;
                    busy_r    <= 1'b0;
                    ready_r   <= 1'b1;
                end
            endcase
        end
    end

    assign txd            = txd_r;
    assign busy           = busy_r;
    assign tx_if.tx_ready = ready_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three parameter sets, a frame-level reference model,
// a table of known frames, hand-written corner sequences and a loopback receiver.
`timescale 1ns/1ps
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int N     = 3;
    localparam int CPB_A = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         gl_reset;
    logic [N-1:0] vld;
    logic [7:0]   dat [N];
    logic [N-1:0] txd_o;
    logic [N-1:0] busy_o;
    logic [N-1:0] rdy_o;

    uart_tx_if #(.DATA_BITS(8)) if_a ();
    uart_tx_if #(.DATA_BITS(8)) if_b ();
    uart_tx_if #(.DATA_BITS(5)) if_c ();

    assign if_a.tx_valid = vld[0];
    assign if_a.tx_data  = dat[0];
    assign if_b.tx_valid = vld[1];
    assign if_b.tx_data  = dat[1];
    assign if_c.tx_valid = vld[2];
    assign if_c.tx_data  = dat[2][4:0];
    assign rdy_o[0] = if_a.tx_ready;
    assign rdy_o[1] = if_b.tx_ready;
    assign rdy_o[2] = if_c.tx_ready;

    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .reset(reset), .gl_reset(gl_reset), .tx_if(if_a), .txd(txd_o[0]), .busy(busy_o[0]));
    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .clk(clk), .reset(reset), .gl_reset(gl_reset), .tx_if(if_b), .txd(txd_o[1]), .busy(busy_o[1]));
    uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(5), .STOP_BITS(1), .PARITY_ODD(1)) dut_c (
        .clk(clk), .reset(reset), .gl_reset(gl_reset), .tx_if(if_c), .txd(txd_o[2]), .busy(busy_o[2]));

    int checks = 0;
    int errors = 0;

    // Reference model: position within the current frame (0 = idle) and the frame's bit list.
    int          cpb   [N];
    int          dbits [N];
    int          sbits [N];
    int          podd  [N];
    int          flen  [N];
    int          pos   [N];
    logic [15:0] fbits [N];

    logic       lb_on;
    logic [7:0] sent_q [$];
    logic [7:0] rx_q [$];
    logic       rx_act;
    int         rx_t;
    logic [7:0] rx_byte;

    typedef struct packed {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par_even;
    } vec_t;
    vec_t tbl [7];

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] build_frame(input int k, input logic [7:0] d);
        logic [15:0] f;
        int          n;
        logic        p;
        f = 16'hFFFF;
        f[0] = 1'b0;
        n = 1;
        p = podd[k][0];
        for (int i = 0; i < dbits[k]; i++) begin
            f[n] = d[i];
            p = p ^ d[i];
            n++;
        end
        if (PAR == 1) f[n] = p;
        return f;
    endfunction

    function automatic logic exp_txd(input int k);
        if (pos[k] == 0) return 1'b1;
        return fbits[k][(pos[k] - 1) / cpb[k]];
    endfunction

    task automatic model_step();
        logic r_m;
        for (int k = 0; k < N; k++) begin
            r_m = (pos[k] == 0) || (pos[k] == flen[k]);
            if (reset || gl_reset) begin
                pos[k] = 0;
            end else if (vld[k] && r_m) begin
                pos[k] = 1;
                fbits[k] = build_frame(k, dat[k]);
                if (k == 0 && lb_on) sent_q.push_back(dat[0]);
            end else if (pos[k] == flen[k]) begin
                pos[k] = 0;
            end else if (pos[k] > 0) begin
                pos[k]++;
            end
        end
    endtask

    // Behavioural receiver on dut_a: sample each bit at mid-period after the falling edge.
    task automatic rx_step(input logic was_reset);
        int kb;
        if (!lb_on || was_reset) begin
            rx_act = 1'b0;
            return;
        end
        if (!rx_act) begin
            if (txd_o[0] == 1'b0) begin
                rx_act = 1'b1;
                rx_t = 0;
            end
        end else begin
            rx_t++;
        end
        if (rx_act && (rx_t % CPB_A) == CPB_A / 2) begin
            kb = rx_t / CPB_A;
            if (kb == 0) chk_bit("rx_start", txd_o[0], 1'b0);
            else if (kb <= 8) rx_byte[kb-1] = txd_o[0];
            else if (PAR == 1 && kb == 9) chk_bit("rx_parity", txd_o[0], ^rx_byte);
            else begin
                chk_bit("rx_stop", txd_o[0], 1'b1);
                rx_q.push_back(rx_byte);
                rx_act = 1'b0;
            end
        end
    endtask

    task automatic tick();
        logic was_reset;
        @(posedge clk);
        was_reset = reset | gl_reset;
        model_step();
        #1;
        for (int k = 0; k < N; k++) begin
            chk_bit($sformatf("txd%0d", k), txd_o[k], exp_txd(k));
            chk_bit($sformatf("busy%0d", k), busy_o[k], pos[k] != 0);
            chk_bit($sformatf("ready%0d", k), rdy_o[k], (pos[k] == 0) || (pos[k] == flen[k]));
        end
        rx_step(was_reset);
    endtask

    task automatic check_frame_a(input logic [7:0] d, input logic [9:0] fr, input logic pe);
        int   fl;
        int   busy_n;
        int   b;
        logic eb;
        fl = (10 + PAR) * CPB_A;
        vld[0] = 1'b1;
        dat[0] = d;
        tick();
        vld[0] = 1'b0;
        dat[0] = 8'($urandom);
        busy_n = 0;
        for (int c = 1; c <= fl; c++) begin
            if (busy_o[0]) busy_n++;
            if ((c - 1) % CPB_A == CPB_A / 2) begin
                b = (c - 1) / CPB_A;
                if (b < 9) eb = fr[b];
                else if (PAR == 1 && b == 9) eb = pe;
                else eb = 1'b1;
                chk_bit("frame_bit", txd_o[0], eb);
            end
            chk_bit("frame_ready", rdy_o[0], c == fl);
            tick();
        end
        chk_int("frame_busy_len", busy_n, fl);
        chk_bit("frame_idle", busy_o[0], 1'b0);
    endtask

    initial begin
        int busy_n;
        int cyc;
        int fl;
        cpb   = '{4, 4, 2};
        dbits = '{8, 8, 5};
        sbits = '{1, 2, 1};
        podd  = '{0, 1, 1};
        for (int k = 0; k < N; k++) begin
            flen[k]  = (1 + dbits[k] + PAR + sbits[k]) * cpb[k];
            pos[k]   = 0;
            fbits[k] = 16'hFFFF;
            dat[k]   = 8'h00;
        end
        tbl[0] = {8'hA5, 10'b1101001010, 1'b0};
        tbl[1] = {8'h00, 10'b1000000000, 1'b0};
        tbl[2] = {8'hFF, 10'b1111111110, 1'b0};
        tbl[3] = {8'h3C, 10'b1001111000, 1'b0};
        tbl[4] = {8'h55, 10'b1010101010, 1'b0};
        tbl[5] = {8'h01, 10'b1000000010, 1'b1};
        tbl[6] = {8'h07, 10'b1000001110, 1'b1};
        reset = 1'b1;
        gl_reset = 1'b0;
        vld = '0;
        lb_on = 1'b0;
        rx_act = 1'b0;
        rx_t = 0;
        rx_byte = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        for (int k = 0; k < N; k++) begin
            chk_bit("rst_txd", txd_o[k], 1'b1);
            chk_bit("rst_ready", rdy_o[k], 1'b1);
            chk_bit("rst_busy", busy_o[k], 1'b0);
        end

        // Known frames on the 4-clock, 8N1 instance.
        for (int i = 0; i < 7; i++) begin
            check_frame_a(tbl[i].data, tbl[i].frame, tbl[i].par_even);
            repeat (2) tick();
        end

        // Back-to-back with tx_valid held high: 0x00 then 0xFF, no idle gap.
        fl = (10 + PAR) * CPB_A;
        vld[0] = 1'b1;
        dat[0] = 8'h00;
        tick();
        dat[0] = 8'hFF;
        busy_n = 0;
        for (int c = 0; c < 400 && busy_o[0]; c++) begin
            busy_n++;
            if (pos[0] == flen[0] && vld[0]) begin
                tick();
                vld[0] = 1'b0;
                chk_bit("b2b_start", txd_o[0], 1'b0);
            end else begin
                tick();
            end
        end
        chk_int("b2b_busy_len", busy_n, 2 * fl);
        tick();

        // Reset during data bit 3, then a clean 0x55 frame.
        vld[0] = 1'b1;
        dat[0] = 8'hA5;
        tick();
        vld[0] = 1'b0;
        repeat (17) tick();
        chk_bit("mid_busy_before", busy_o[0], 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_bit("mid_rst_txd", txd_o[0], 1'b1);
        chk_bit("mid_rst_busy", busy_o[0], 1'b0);
        chk_bit("mid_rst_ready", rdy_o[0], 1'b1);
        tick();
        chk_bit("mid_rst_noqueue", busy_o[0], 1'b0);
        check_frame_a(8'h55, 10'b1010101010, 1'b0);

        // Global reset during the start bit.
        vld[0] = 1'b1;
        dat[0] = 8'h3C;
        tick();
        vld[0] = 1'b0;
        tick();
        gl_reset = 1'b1;
        tick();
        gl_reset = 1'b0;
        chk_bit("glrst_txd", txd_o[0], 1'b1);
        chk_bit("glrst_busy", busy_o[0], 1'b0);

        // Reset and handshake on the same edge: the byte is dropped.
        vld[0] = 1'b1;
        dat[0] = 8'h81;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vld[0] = 1'b0;
        chk_bit("rst_hs_busy", busy_o[0], 1'b0);
        tick();
        chk_bit("rst_hs_drop", busy_o[0], 1'b0);
        chk_bit("rst_hs_txd", txd_o[0], 1'b1);

        // Two stop bits: line high for the last 8 cycles, ready only in the very last one.
        vld[1] = 1'b1;
        dat[1] = 8'h3C;
        tick();
        vld[1] = 1'b0;
        for (int c = 1; c <= flen[1]; c++) begin
            chk_bit("stop2_ready", rdy_o[1], c == flen[1]);
            if (c > flen[1] - 8) chk_bit("stop2_txd", txd_o[1], 1'b1);
            tick();
        end
        chk_bit("stop2_idle", busy_o[1], 1'b0);

        // Random traffic on all instances; 256 bytes looped back through the receiver model.
        lb_on = 1'b1;
        sent_q.delete();
        rx_q.delete();
        rx_act = 1'b0;
        cyc = 0;
        while (sent_q.size() < 256 && cyc < 30000) begin
            for (int k = 0; k < N; k++) begin
                vld[k] = ($urandom_range(0, 3) != 0);
                dat[k] = 8'($urandom);
            end
            tick();
            cyc++;
        end
        vld = '0;
        repeat (100) tick();
        chk_int("lb_sent", sent_q.size(), 256);
        chk_int("lb_recv", rx_q.size(), sent_q.size());
        for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++) begin
            chk_int("lb_byte", int'(rx_q[i]), int'(sent_q[i]));
        end
        lb_on = 1'b0;

        // Random traffic with sporadic resets on either reset input.
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) begin
                vld[k] = ($urandom_range(0, 2) != 0);
                dat[k] = 8'($urandom);
            end
            reset    = ($urandom_range(0, 149) == 0);
            gl_reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        gl_reset = 1'b0;
        vld = '0;
        repeat (60) tick();
        for (int k = 0; k < N; k++) begin
            chk_bit("final_idle", busy_o[k], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
